counter_sequencer: RTL

Run/pause/stop controller for the lab board's 8-bit event counter. It replaces the ripple-divided clock with a single-clock prescaler that produces a one-cycle tick enable. It sequences an up or down count toward a programmable terminal value, with optional auto-reload. Sits between the board buttons/switches and the LED count display.

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/counter_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default sizing for the event counter sequencer
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam int unsigned DEFAULT_DIV_WIDTH = 27;
  localparam int unsigned DEFAULT_DIV_MAX   = 67108863;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - single-clock divider producing a raw step strobe every DIV_MAX+1 enabled clocks
module tick_prescaler #(
  parameter int unsigned DIV_WIDTH = 27,
  parameter int unsigned DIV_MAX   = 67108863
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic hold,
  input  logic restart,
  output logic tick_raw
);

  localparam logic [DIV_WIDTH-1:0] DIV_TERM = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] div_cnt;

  assign tick_raw = en && (div_cnt == DIV_TERM);

  // hold keeps the phase across a pause so resume does not restart the interval
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (restart) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_TERM) ? '0 : div_cnt + DIV_WIDTH'(1);
    end else if (!hold) begin
      div_cnt <= '0;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run/pause/stop sequencer stepping an up/down count toward a captured terminal
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DIV_WIDTH = DEFAULT_DIV_WIDTH,
  parameter int unsigned DIV_MAX   = DEFAULT_DIV_MAX
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             tick_d, done_d;
  logic             tick_raw;
  logic             restart;
  logic             at_terminal;
  logic             launch;

  // a fresh launch (from IDLE or DONE) and any clear both zero the prescaler
  assign launch  = (state_q == ST_IDLE || state_q == ST_DONE) && start && !stop;
  assign restart = clear || launch;

  tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .en       (state_q == ST_RUN),
    .hold     (state_q == ST_PAUSE),
    .restart  (restart),
    .tick_raw (tick_raw)
  );

  assign at_terminal = dir_q ? (count == limit_q) : (count == '0);

  always_comb begin
    state_d = state_q;
    count_d = count;
    dir_d   = dir_q;
    limit_d = limit_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state_d = ST_RUN;
            dir_d   = dir;
            limit_d = limit;
            count_d = dir ? '0 : limit;
          end
        end
        ST_RUN: begin
          if (tick_raw) begin
            tick_d = 1'b1;
            // terminal is tested on the pre-step value so count never overshoots
            if (at_terminal) begin
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = dir_q ? '0 : limit_q;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = dir_q ? count + WIDTH'(1) : count - WIDTH'(1);
            end
          end
          if (stop) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count   <= '0;
      dir_q   <= 1'b1;
      limit_q <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
      tick    <= tick_d;
      done    <= done_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign state   = state_q;

endmodule
